strobe_scheduler: RTL
=====================

Name: strobe_scheduler

Overview:
- Multi-channel periodic strobe generator that time-shares one compare/increment datapath across CHANNELS independent counters.
- A round-robin scan pointer services one channel per enabled clock.
- Each channel has a programmable period written over a valid/ready configuration port.
- Replaces a bank of per-channel counter_with_strobe instances where many slow timers are needed.

Parameters:
- WIDTH, 16, width of the period and per-channel count registers.
- CHANNELS, 4, number of channels; must be at least 2.
- CH_W, $clog2(CHANNELS), derived channel index width; not to be overridden.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-low reset.
- enable  input  1  global run; the scan pointer and counters advance only when high.
- cfg_valid  input  1  configuration write request.
- cfg_ready  output  1  configuration port can accept a write.
- cfg_channel  input  CH_W  target channel of the write.
- cfg_period  input  WIDTH  new period for the target channel.
- cfg_enable  input  1  new channel-enable for the target channel.
- cfg_oneshot  input  1  one-shot mode request; honoured only with the optional feature compiled in.
- cfg_err  output  1  one-cycle pulse when an accepted write targets cfg_channel >= CHANNELS.
- strobe  output  CHANNELS  one-hot, one-cycle pulse per channel.
- strobe_valid  output  1  high whenever any strobe bit is high.
- strobe_channel  output  CH_W  index of the pulsing channel; 0 when strobe_valid is low.
- ch_active  output  CHANNELS  current per-channel enable bits.

Behaviour:
- Reset (rst low at a posedge):
  - period[i]=0, ch_en[i]=0, count[i]=1, ptr=0.
  - strobe=0, strobe_valid=0, strobe_channel=0, cfg_err=0, cfg_ready=0.
  - Reset mid-operation discards all pending state; no strobe follows.
- Scan pointer:
  - When enable=1, ptr advances to (ptr+1) mod CHANNELS every cycle, wrapping from CHANNELS-1 to 0.
  - When enable=0, ptr holds and no channel is serviced.
- Servicing channel c=ptr (only when enable=1):
  - If ch_en[c]=1 and period[c]>=2:
    - If count[c]==period[c]: count[c] is set to 1, and strobe[c], strobe_valid=1 and strobe_channel=c are registered for the next cycle.
    - Otherwise count[c] is incremented by 1.
  - If ch_en[c]=0 or period[c]<2: count[c] is forced to 1 and no strobe is produced.
- Latency and spacing:
  - A strobe appears exactly 1 cycle after the service cycle.
  - With enable held high, channel c strobes once every period[c]*CHANNELS cycles.
  - At most one strobe bit is set in any cycle; all strobe outputs return to 0 in the following cycle unless a new strobe is produced.
- Config handshake:
  - A write is accepted when cfg_valid & cfg_ready.
  - cfg_ready is 0 in the cycle after reset deasserts is seen; it is 1 afterwards.
  - cfg_ready drops to 0 for exactly 1 cycle after each accepted write, limiting writes to 1 per 2 cycles.
  - An accepted write sets period[ch]=cfg_period, ch_en[ch]=cfg_enable and count[ch]=1, taking effect on the next cycle.
- Collision: if the written channel is serviced in the same cycle, the write wins; there is no strobe and no increment for that visit.
- Out-of-range channel: an accepted write with cfg_channel >= CHANNELS is consumed with no state change, and cfg_err pulses 1 cycle later.
- Wrap: count never exceeds period; lowering period below count via a write is safe because count resets to 1.

Optional Feature:
- Macro: STROBE_SCHEDULER_ONESHOT_EN.
- Defined:
  - A per-channel oneshot bit is stored from cfg_oneshot on each accepted write and is cleared by reset.
  - When a oneshot channel strobes, ch_en for that channel is cleared in the same cycle the strobe is registered, giving exactly one strobe per write.
- Undefined:
  - cfg_oneshot is ignored and no oneshot storage exists.
  - All channels are periodic.

Test Plan:
- Reset behaviour → with rst=0 for 3 cycles, all outputs are 0 and ch_active=0. After rst rises, cfg_ready=0 for 1 cycle, then 1.
- Periodic strobe:
  - Stimulus: CHANNELS=4, WIDTH=8; write ch1 period=3 enable=1; then enable=1 from cycle 0 with ptr=0.
  - Required response: ch1 is serviced at cycles 1, 5 and 9, strobe[1] pulses at cycle 10, then every 12 cycles.
  - Check strobe_channel=1 and strobe_valid=1 only on those cycles.
- Enable gap → same setup with enable dropped low for 5 cycles at cycle 3 → first strobe[1] moves to cycle 15, and subsequent spacing stays 12.
- Degenerate periods:
  - Stimulus: ch0 period=0, ch2 period=1, ch3 enable=0 with period=4; run 100 cycles.
  - Required response: no strobe on channels 0, 2 or 3, and count holds at 1.
- Collision and back-to-back writes:
  - Rewrite ch1 period=2 in the cycle ch1 is serviced while count==period → no strobe that visit, and the next strobe comes 2 visits later.
  - Two consecutive cfg_valid cycles → the second write is accepted only after the 1-cycle cfg_ready gap.
- Out-of-range write and oneshot:
  - With CHANNELS=6, a write with cfg_channel=7 → cfg_err pulses once and ch_active is unchanged.
  - With STROBE_SCHEDULER_ONESHOT_EN defined, ch2 period=2 oneshot=1 → exactly one strobe[2], then ch_active[2]=0.

Source files
------------

// File: rtl/strobe_scheduler.sv
// strobe_scheduler: CHANNELS periodic strobe timers sharing one compare/increment datapath.
// Optional one-shot channels are compiled in with `define STROBE_SCHEDULER_ONESHOT_EN.
module strobe_scheduler #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4,
  localparam int unsigned CH_W    = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic [CH_W-1:0]     cfg_channel,
  input  logic [WIDTH-1:0]    cfg_period,
  input  logic                cfg_enable,
  input  logic                cfg_oneshot,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] strobe,
  output logic                strobe_valid,
  output logic [CH_W-1:0]     strobe_channel,
  output logic [CHANNELS-1:0] ch_active
);

  logic [CH_W-1:0]     ptr_q, ptr_d;
  logic [WIDTH-1:0]    period_q [CHANNELS];
  logic [WIDTH-1:0]    period_d [CHANNELS];
  logic [WIDTH-1:0]    count_q  [CHANNELS];
  logic [WIDTH-1:0]    count_d  [CHANNELS];
  logic [CHANNELS-1:0] ch_en_q, ch_en_d;
  logic [CHANNELS-1:0] strobe_q, strobe_d;
  logic                strobe_valid_q, strobe_valid_d;
  logic [CH_W-1:0]     strobe_channel_q, strobe_channel_d;
  logic                cfg_err_q, cfg_err_d;
  logic                cfg_ready_q, cfg_ready_d;
  logic                up_q;
  logic                accept;
  logic                in_range;

`ifdef STROBE_SCHEDULER_ONESHOT_EN
  logic [CHANNELS-1:0] oneshot_q, oneshot_d;
`else
  logic unused_oneshot;
  assign unused_oneshot = cfg_oneshot;
`endif

  // Scan, service and configuration next-state; a write to the serviced channel wins.
  always_comb begin
    ptr_d            = ptr_q;
    period_d         = period_q;
    count_d          = count_q;
    ch_en_d          = ch_en_q;
    strobe_d         = '0;
    strobe_valid_d   = 1'b0;
    strobe_channel_d = '0;
    in_range         = 1'b0;
`ifdef STROBE_SCHEDULER_ONESHOT_EN
    oneshot_d        = oneshot_q;
`endif
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cfg_channel == CH_W'(i)) in_range = 1'b1;
    end
    accept      = cfg_valid & cfg_ready_q;
    cfg_err_d   = accept & ~in_range;
    cfg_ready_d = up_q & ~accept;

    if (enable) begin
      ptr_d = (ptr_q == CH_W'(CHANNELS - 1)) ? '0 : ptr_q + CH_W'(1);
    end

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (accept && cfg_channel == CH_W'(i)) begin
        period_d[i] = cfg_period;
        ch_en_d[i]  = cfg_enable;
        count_d[i]  = WIDTH'(1);
`ifdef STROBE_SCHEDULER_ONESHOT_EN
        oneshot_d[i] = cfg_oneshot;
`endif
      end else if (enable && ptr_q == CH_W'(i)) begin
        if (ch_en_q[i] && period_q[i] >= WIDTH'(2)) begin
          if (count_q[i] == period_q[i]) begin
            count_d[i]       = WIDTH'(1);
            strobe_d[i]      = 1'b1;
            strobe_valid_d   = 1'b1;
            strobe_channel_d = CH_W'(i);
`ifdef STROBE_SCHEDULER_ONESHOT_EN
            if (oneshot_q[i]) ch_en_d[i] = 1'b0;
`endif
          end else begin
            count_d[i] = count_q[i] + WIDTH'(1);
          end
        end else begin
          count_d[i] = WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q            <= '0;
      ch_en_q          <= '0;
      strobe_q         <= '0;
      strobe_valid_q   <= 1'b0;
      strobe_channel_q <= '0;
      cfg_err_q        <= 1'b0;
      cfg_ready_q      <= 1'b0;
      up_q             <= 1'b0;
`ifdef STROBE_SCHEDULER_ONESHOT_EN
      oneshot_q        <= '0;
`endif
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        period_q[i] <= '0;
        count_q[i]  <= WIDTH'(1);
      end
    end else begin
      ptr_q            <= ptr_d;
      period_q         <= period_d;
      count_q          <= count_d;
      ch_en_q          <= ch_en_d;
      strobe_q         <= strobe_d;
      strobe_valid_q   <= strobe_valid_d;
      strobe_channel_q <= strobe_channel_d;
      cfg_err_q        <= cfg_err_d;
      cfg_ready_q      <= cfg_ready_d;
      up_q             <= 1'b1;
`ifdef STROBE_SCHEDULER_ONESHOT_EN
      oneshot_q        <= oneshot_d;
`endif
    end
  end

  assign cfg_ready      = cfg_ready_q;
  assign cfg_err        = cfg_err_q;
  assign strobe         = strobe_q;
  assign strobe_valid   = strobe_valid_q;
  assign strobe_channel = strobe_channel_q;
  assign ch_active      = ch_en_q;

endmodule
